run_det_sched: RTL and testbench

RUN_DET_SCHED -- requirements
Module: run_det_sched

---
 rtl/run_det_pkg.sv | 18 +
 rtl/run_det_core.sv | 27 ++
 rtl/run_det_sched.sv | 135 +++++++++++++
 tb/tb_run_det_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared defaults and width helpers for the run-length detect scheduler.
package run_det_pkg;

  localparam int NCH_DEF     = 4;
  localparam int RUN_LEN_DEF = 3;
  localparam int DCNT_W      = 8;

  // Width needed to hold a run count of 0..run_len.
  function automatic int cnt_w(input int run_len);
    return (run_len < 1) ? 1 : $clog2(run_len + 1);
  endfunction

  // Width of a channel index (det_ch, cnt_sel, pointer).
  function automatic int ch_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/run_det_core.sv
// Next run count and detect flag for one consumed bit of the granted channel.
module run_det_core
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int CW      = cnt_w(RUN_LEN)
) (
  input  logic [CW-1:0] cnt_cur,
  input  logic          bit_val,
  output logic [CW-1:0] cnt_nxt,
  output logic          hit
);

  localparam logic [CW-1:0] SAT = CW'(RUN_LEN);

  always_comb begin
    cnt_nxt = '0;
    hit     = 1'b0;
    if (bit_val) begin
      cnt_nxt = (cnt_cur >= SAT) ? SAT : cnt_cur + 1'b1;
    end else begin
      // A consumed 0 always restarts the run; it detects only after a full run.
      hit = (cnt_cur >= SAT);
    end
  end

endmodule

// File: rtl/run_det_sched.sv
// Round-robin serial-channel scheduler with per-channel run-of-1s detection.
// Optional per-channel detection counters are enabled with `define DET_CNT_EN.
module run_det_sched
  import run_det_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         bit_in,
  output logic [NCH-1:0]         gnt,
  output logic                   det,
  output logic [ch_w(NCH)-1:0]   det_ch
`ifdef DET_CNT_EN
  ,
  input  logic [ch_w(NCH)-1:0]   cnt_sel,
  output logic [DCNT_W-1:0]      cnt_out
`endif
);

  localparam int CHW = ch_w(NCH);
  localparam int CW  = cnt_w(RUN_LEN);

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic           det_q, det_d;
  logic [CHW-1:0] det_ch_q, det_ch_d;

  logic [CHW-1:0] gnt_idx;
  logic [CHW-1:0] idx;
  logic           gnt_vld;
  logic [CW-1:0]  cur_cnt;
  logic           cur_bit;
  logic [CW-1:0]  nxt_cnt;
  logic           hit;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    if (en && !rst && !clr && (|req)) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = ptr_q + CHW'(k);
        if (!gnt_vld && req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  assign cur_cnt = cnt_q[gnt_idx];
  assign cur_bit = bit_in[gnt_idx];

  run_det_core #(
    .RUN_LEN (RUN_LEN),
    .CW      (CW)
  ) u_core (
    .cnt_cur (cur_cnt),
    .bit_val (cur_bit),
    .cnt_nxt (nxt_cnt),
    .hit     (hit)
  );

  always_comb begin
    ptr_d    = ptr_q;
    det_d    = 1'b0;
    det_ch_d = det_ch_q;
    for (int i = 0; i < NCH; i++) cnt_d[i] = cnt_q[i];
    if (clr) begin
      for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
    end else if (gnt_vld) begin
      cnt_d[gnt_idx] = nxt_cnt;
      ptr_d          = gnt_idx;
      if (hit) begin
        det_d    = 1'b1;
        det_ch_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= CHW'(NCH - 1);
      det_q    <= 1'b0;
      det_ch_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      det_q    <= det_d;
      det_ch_q <= det_ch_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign det    = det_q;
  assign det_ch = det_ch_q;

`ifdef DET_CNT_EN
  logic [DCNT_W-1:0] dcnt_q [NCH];
  logic [DCNT_W-1:0] dcnt_d [NCH];

  // Counters advance on the same edge that registers the det pulse.
  always_comb begin
    for (int i = 0; i < NCH; i++) dcnt_d[i] = dcnt_q[i];
    if (clr) begin
      for (int i = 0; i < NCH; i++) dcnt_d[i] = '0;
    end else if (det_d && (dcnt_q[det_ch_d] != {DCNT_W{1'b1}})) begin
      dcnt_d[det_ch_d] = dcnt_q[det_ch_d] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) dcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign cnt_out = dcnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_run_det_sched.sv
// Bench for run_det_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_run_det_sched;

  localparam int NCH     = 4;
  localparam int RUN_LEN = 3;
  localparam int CHW     = 2;

  logic           clk;
  logic           rst;
  logic           en;
  logic           clr;
  logic [NCH-1:0] req;
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] gnt;
  logic           det;
  logic [CHW-1:0] det_ch;
`ifdef DET_CNT_EN
  logic [CHW-1:0] cnt_sel;
  logic [7:0]     cnt_out;
`endif

  run_det_sched #(
    .NCH     (NCH),
    .RUN_LEN (RUN_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .req     (req),
    .bit_in  (bit_in),
    .gnt     (gnt),
    .det     (det),
    .det_ch  (det_ch)
`ifdef DET_CNT_EN
    ,
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: state as it must be after the most recent rising edge.
  int m_cnt  [NCH] = '{default: 0};
  int m_dcnt [NCH] = '{default: 0};
  int m_ptr        = NCH - 1;
  int m_det        = 0;
  int m_det_ch     = 0;
  int g;
  int c;

  always @(negedge clk) begin
    g = -1;
    if (!rst && en && !clr && (req != '0)) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (g < 0 && req[c]) g = c;
      end
    end
    check("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("det", 32'(det), 32'(m_det));
    check("det_ch", 32'(det_ch), 32'(m_det_ch));
`ifdef DET_CNT_EN
    check("cnt_out", 32'(cnt_out), 32'(m_dcnt[cnt_sel]));
`endif
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i]  = 0;
        m_dcnt[i] = 0;
      end
      m_ptr = NCH - 1; m_det = 0; m_det_ch = 0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i]  = 0;
        m_dcnt[i] = 0;
      end
      m_det = 0;
    end else begin
      m_det = 0;
      if (g >= 0) begin
        if (bit_in[g]) begin
          m_cnt[g] = (m_cnt[g] + 1 > RUN_LEN) ? RUN_LEN : m_cnt[g] + 1;
        end else begin
          if (m_cnt[g] == RUN_LEN) begin
            m_det    = 1;
            m_det_ch = g;
            if (m_dcnt[g] < 255) m_dcnt[g]++;
          end
          m_cnt[g] = 0;
        end
        m_ptr = g;
      end
    end
  end

  task automatic cyc(input logic e, input logic c_in, input logic [NCH-1:0] r, input logic [NCH-1:0] b);
    en = e; clr = c_in; req = r; bit_in = b;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; req = '0; bit_in = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [NCH-1:0] rr_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int ndet;
  logic           e_r, c_r;
  logic [NCH-1:0] r_r, b_r;

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; req = '0; bit_in = '0;
`ifdef DET_CNT_EN
    cnt_sel = '0;
`endif
    do_reset();
    check("reset_det", 32'(det), 32'd0);
    check("reset_det_ch", 32'(det_ch), 32'd0);

    // Run of three 1s then a 0 on channel 0.
    cyc(1, 0, 4'b0001, 4'b0001);
    cyc(1, 0, 4'b0001, 4'b0001);
    cyc(1, 0, 4'b0001, 4'b0001);
    check("run3_pre", 32'(det), 32'd0);
    cyc(1, 0, 4'b0001, 4'b0000);
    check("run3_det", 32'(det), 32'd1);
    check("run3_det_ch", 32'(det_ch), 32'd0);
    cyc(1, 0, 4'b0000, 4'b0000);
    check("run3_pulse_end", 32'(det), 32'd0);
    check("run3_ch_hold", 32'(det_ch), 32'd0);

    // Short run: no detection; long run: exactly one.
    cyc(1, 0, 4'b0001, 4'b0001);
    cyc(1, 0, 4'b0001, 4'b0001);
    cyc(1, 0, 4'b0001, 4'b0000);
    check("short_run", 32'(det), 32'd0);
    ndet = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 4'b0001, 4'b0001);
      ndet += int'(det);
    end
    cyc(1, 0, 4'b0001, 4'b0000);
    ndet += int'(det);
    check("long_run_det", 32'(det), 32'd1);
    cyc(1, 0, 4'b0000, 4'b0000);
    ndet += int'(det);
    check("long_run_count", 32'(ndet), 32'd1);

    // Round-robin order with all channels requesting.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; clr = 1'b0; req = 4'b1111; bit_in = '0;
      #1;
      check("rr_gnt", 32'(gnt), 32'(rr_seq[i]));
      @(posedge clk); #1;
    end

    // clr in the same cycle as a detecting 0 on channel 2.
    do_reset();
    cyc(1, 0, 4'b0100, 4'b0100);
    cyc(1, 0, 4'b0100, 4'b0100);
    cyc(1, 0, 4'b0100, 4'b0100);
    cyc(1, 1, 4'b0100, 4'b0000);
    check("clr_no_det", 32'(det), 32'd0);
    cyc(1, 0, 4'b0100, 4'b0100);
    cyc(1, 0, 4'b0100, 4'b0100);
    cyc(1, 0, 4'b0100, 4'b0000);
    check("clr_count_zero", 32'(det), 32'd0);

    // en low mid-run on channel 1 holds the count.
    do_reset();
    cyc(1, 0, 4'b0010, 4'b0010);
    cyc(1, 0, 4'b0010, 4'b0010);
    en = 1'b0; req = 4'b0010; bit_in = 4'b0000; #1;
    check("en0_gnt", 32'(gnt), 32'd0);
    cyc(0, 0, 4'b0010, 4'b0000);
    check("en0_det", 32'(det), 32'd0);
    cyc(0, 0, 4'b0010, 4'b0000);
    cyc(1, 0, 4'b0010, 4'b0010);
    cyc(1, 0, 4'b0010, 4'b0000);
    check("en_resume_det", 32'(det), 32'd1);
    check("en_resume_ch", 32'(det_ch), 32'd1);

    // Randomized traffic; the negedge process checks every cycle.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      e_r = ($urandom_range(0, 9) != 0);
      c_r = ($urandom_range(0, 49) == 0);
      r_r = NCH'($urandom);
      for (int j = 0; j < NCH; j++) b_r[j] = ($urandom_range(0, 3) != 0);
`ifdef DET_CNT_EN
      cnt_sel = CHW'($urandom);
`endif
      cyc(e_r, c_r, r_r, b_r);
    end
    rst = 1'b0;

`ifdef DET_CNT_EN
    do_reset();
    cnt_sel = 2'd3;
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 4'b1000, 4'b1000);
      cyc(1, 0, 4'b1000, 4'b1000);
      cyc(1, 0, 4'b1000, 4'b1000);
      cyc(1, 0, 4'b1000, 4'b0000);
    end
    check("dcnt_sat", 32'(cnt_out), 32'd255);
    cyc(0, 1, 4'b0000, 4'b0000);
    check("dcnt_clr", 32'(cnt_out), 32'd0);
`endif

    cyc(0, 0, 4'b0000, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
